// File: rtl/unified_memory_arbiter.sv
// Arbiter sharing one instruction/data memory between the fetch (IF) and load/store (DM) ports.
// One access at a time: grant in IDLE, hold on the memory for MEM_LATENCY cycles, one-cycle ack in DONE.
module unified_memory_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_ack_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  dm_ack_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [3:0] LAST_CNT   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            starve_q, starve_d;
  logic                  grant_dm_q, grant_dm_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

  logic busy;
  logic take_dm;
  logic take_if;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      grant_dm_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      grant_dm_q <= grant_dm_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    grant_dm_d = grant_dm_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    busy    = (state_q == BUSY_IF) || (state_q == BUSY_DM);
    // Data wins unless fetch has already waited out STARVE_LIMIT data grants.
    take_dm = (state_q == IDLE) && dm_req_i && (!if_req_i || (starve_q < STARVE_MAX));
    take_if = (state_q == IDLE) && !take_dm && if_req_i;

    unique case (state_q)
      IDLE: begin
        if (take_dm) begin
          state_d    = BUSY_DM;
          grant_dm_d = 1'b1;
          addr_d     = dm_addr_i;
          we_d       = dm_we_i;
          wdata_d    = dm_wdata_i;
          cnt_d      = '0;
        end else if (take_if) begin
          state_d    = BUSY_IF;
          grant_dm_d = 1'b0;
          addr_d     = if_addr_i;
          we_d       = 1'b0;
          cnt_d      = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
          if (state_q == BUSY_IF) begin
            if_rdata_d = mem_rdata_i;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Counts data grants taken while a fetch was waiting; any fetch grant or idle fetch clears it.
    if (!if_req_i || take_if) begin
      starve_d = '0;
    end else if (take_dm && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  assign mem_en_o    = busy;
  assign mem_we_o    = busy & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = (state_q == DONE) & ~grant_dm_q;
  assign dm_ack_o    = (state_q == DONE) & grant_dm_q;
  // Gated by reset so every output reads 0 while reset is held.
  assign stall_o     = ~reset & ((if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o));

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Randomized bench for unified_memory_arbiter: two requester drivers, a latency-accurate memory,
// and a negedge monitor checking grants, timing and read data against a transaction-level model.
module tb_unified_memory_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int LAT     = 2;
  localparam int LIM     = 4;
  localparam int TIMEOUT = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_ack_o;
  logic          dm_req_i;
  logic          dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_ack_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          stall_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] dm_exp_q[$];
  logic [DW-1:0] dm_last_exp;

  unified_memory_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: read data is only correct on the last cycle of the access, garbage otherwise.
  logic [3:0] run_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) run_cnt <= '0;
    else if (mem_en_o) run_cnt <= run_cnt + 4'd1;
    else run_cnt <= '0;
  end
  assign mem_rdata_i = (mem_en_o && run_cnt == 4'(LAT - 1)) ? mem_fn(mem_addr_o) : ~mem_fn(mem_addr_o);

  // ---------------- driver tasks ----------------
  task automatic if_issue(input logic [AW-1:0] a);
    if_req_i  = 1'b1;
    if_addr_i = a;
    if_exp_q.push_back(mem_fn(a));
  endtask

  task automatic dm_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dm_req_i   = 1'b1;
    dm_we_i    = we;
    dm_addr_i  = a;
    dm_wdata_i = d;
    if (!we) dm_last_exp = mem_fn(a);
    dm_exp_q.push_back(dm_last_exp);
  endtask

  task automatic wait_ack(input bit is_dm);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < TIMEOUT) begin
      @(negedge clk);
      n++;
      seen = is_dm ? dm_ack_o : if_ack_o;
    end
    check(is_dm ? "dm_ack_timeout" : "if_ack_timeout", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic if_stream(input int n);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) gap = 0;
      if (gap > 0) begin
        if_req_i = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      if_issue({16'h0000, 14'($urandom), 2'b00});
      wait_ack(1'b0);
    end
    if_req_i = 1'b0;
  endtask

  task automatic dm_stream(input int n);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 3);
      if ($urandom_range(0, 2) != 0) gap = 0;
      if (gap > 0) begin
        dm_req_i = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      dm_issue(($urandom_range(0, 2) == 0), {16'h8000, 14'($urandom), 2'b00}, $urandom);
      wait_ack(1'b1);
    end
    dm_req_i = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int            starve_m;
  int            run_len;
  bit            prev_en, prev_if, prev_dm;
  bit            cur_dm, exp_dm;
  bit            exp_if_ack, exp_dm_ack;
  logic [AW-1:0] snap_addr, exp_last_addr;
  logic          snap_we;
  logic [DW-1:0] exp_last_wdata;
  int            starve_grants = 0;

  always @(negedge clk) begin
    if (reset) begin
      starve_m       = 0;
      run_len        = 0;
      prev_en        = 1'b0;
      exp_last_addr  = '0;
      exp_last_wdata = '0;
      prev_if        = if_req_i;
      prev_dm        = dm_req_i;
    end else begin
      exp_if_ack = 1'b0;
      exp_dm_ack = 1'b0;
      if (prev_en && !mem_en_o) begin
        check("busy_len", 64'(run_len), 64'(LAT));
        if (cur_dm) exp_dm_ack = 1'b1;
        else exp_if_ack = 1'b1;
      end
      if (!prev_en && mem_en_o) begin
        check("grant_has_req", 64'(prev_if | prev_dm), 64'd1);
        exp_dm = prev_dm && (!prev_if || starve_m < LIM);
        if (prev_dm && prev_if && !exp_dm) starve_grants++;
        check("grant_kind_dm", 64'(mem_addr_o[AW-1]), 64'(exp_dm));
        if (exp_dm) begin
          snap_addr      = dm_addr_i;
          snap_we        = dm_we_i;
          exp_last_wdata = dm_wdata_i;
          if (prev_if) starve_m = (starve_m + 1 > LIM) ? LIM : starve_m + 1;
        end else begin
          snap_addr = if_addr_i;
          snap_we   = 1'b0;
          starve_m  = 0;
        end
        exp_last_addr = snap_addr;
        cur_dm        = exp_dm;
        run_len       = 0;
      end
      if (!prev_if) starve_m = 0;

      if (mem_en_o) begin
        run_len++;
        check("mem_addr", 64'(mem_addr_o), 64'(snap_addr));
        check("mem_we", 64'(mem_we_o), 64'(snap_we));
        check("mem_wdata", 64'(mem_wdata_o), 64'(exp_last_wdata));
      end else begin
        check("idle_we", 64'(mem_we_o), 64'd0);
        check("idle_addr_hold", 64'(mem_addr_o), 64'(exp_last_addr));
        check("idle_wdata_hold", 64'(mem_wdata_o), 64'(exp_last_wdata));
      end

      check("if_ack", 64'(if_ack_o), 64'(exp_if_ack));
      check("dm_ack", 64'(dm_ack_o), 64'(exp_dm_ack));
      if (exp_if_ack) begin
        if (if_exp_q.size() == 0) check("if_q_nonempty", 64'd0, 64'd1);
        else check("if_rdata", 64'(if_rdata_o), 64'(if_exp_q.pop_front()));
      end
      if (exp_dm_ack) begin
        if (dm_exp_q.size() == 0) check("dm_q_nonempty", 64'd0, 64'd1);
        else check("dm_rdata", 64'(dm_rdata_o), 64'(dm_exp_q.pop_front()));
      end
      check("stall", 64'(stall_o),
            64'((if_req_i && !exp_if_ack) || (dm_req_i && !exp_dm_ack)));

      prev_en = mem_en_o;
      prev_if = if_req_i;
      prev_dm = dm_req_i;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    reset       = 1'b1;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    dm_req_i    = 1'b0;
    dm_we_i     = 1'b0;
    dm_addr_i   = '0;
    dm_wdata_i  = '0;
    dm_last_exp = '0;

    // Both requests pending through reset: outputs must read 0, then DM wins first.
    if_issue(32'h0000_0040);
    dm_issue(1'b0, 32'h8000_0100, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_mem_en", 64'(mem_en_o), 64'd0);
    check("rst_mem_we", 64'(mem_we_o), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
    check("rst_if_ack", 64'(if_ack_o), 64'd0);
    check("rst_dm_ack", 64'(dm_ack_o), 64'd0);
    check("rst_if_rdata", 64'(if_rdata_o), 64'd0);
    check("rst_dm_rdata", 64'(dm_rdata_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    fork
      begin wait_ack(1'b1); dm_req_i = 1'b0; end
      begin wait_ack(1'b0); if_req_i = 1'b0; end
    join

    // Random concurrent traffic.
    fork
      if_stream(40);
      dm_stream(60);
    join
    repeat (5) begin @(posedge clk); #1; end
    check("if_q_drained", 64'(if_exp_q.size()), 64'd0);
    check("dm_q_drained", 64'(dm_exp_q.size()), 64'd0);

    // Reset in the first cycle of a data access: abandoned, then re-granted after release.
    @(posedge clk); #1;
    dm_issue(1'b0, 32'h8000_0200, 32'h0000_1234);
    @(posedge clk); #1;
    check("midrst_busy", 64'(mem_en_o), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_en_drop", 64'(mem_en_o), 64'd0);
    check("midrst_no_ack", 64'(dm_ack_o), 64'd0);
    check("midrst_addr_clr", 64'(mem_addr_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_ack(1'b1);
    dm_req_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("final_dm_q_drained", 64'(dm_exp_q.size()), 64'd0);

    $display("starvation-forced fetch grants observed: %0d", starve_grants);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
